// File: rtl/hamming_rx_deserializer.sv
// Receive stage of the (15,11) Hamming decode path: collects one serial
// codeword, corrects any single-bit error and presents the data word downstream.
module hamming_rx_deserializer #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 REST,
  input  logic                 SERIAL_IN,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  output logic [10:0]          DATA_OUT,
  output logic [3:0]           SYNDROME,
  output logic                 ERR_FLAG,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [ERR_CNT_W-1:0] ERR_COUNT
);

  typedef enum logic [1:0] {COLLECT, CHECK, CORRECT, HOLD} state_t;

  state_t      state;
  logic [3:0]  count;
  logic [14:0] code;

  logic [3:0]  syn_calc;
  logic [14:0] corrected;
  logic [10:0] data_calc;

  // The syndrome is the XOR of the position indices of every set bit, which
  // points directly at the flipped position when exactly one bit is wrong.
  always_comb begin
    syn_calc  = '0;
    corrected = code;
    for (int p = 1; p <= 15; p++) begin
      if (code[p-1]) syn_calc = syn_calc ^ 4'(p);
      if (SYNDROME == 4'(p)) corrected[p-1] = ~code[p-1];
    end
    data_calc = {corrected[14:8], corrected[6:4], corrected[2]};
  end

  always_ff @(posedge CLK) begin
    if (REST) begin
      state     <= COLLECT;
      count     <= '0;
      code      <= '0;
      IN_READY  <= 1'b1;
      OUT_VALID <= 1'b0;
      DATA_OUT  <= '0;
      SYNDROME  <= '0;
      ERR_FLAG  <= 1'b0;
      ERR_COUNT <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (IN_VALID && IN_READY) begin
            code[count] <= SERIAL_IN;
            if (count == 4'd14) begin
              count    <= '0;
              IN_READY <= 1'b0;
              state    <= CHECK;
            end else begin
              count <= count + 4'd1;
            end
          end
        end
        CHECK: begin
          SYNDROME <= syn_calc;
          state    <= CORRECT;
        end
        CORRECT: begin
          if (SYNDROME != 4'd0) begin
            ERR_FLAG <= 1'b1;
            if (ERR_COUNT != '1) ERR_COUNT <= ERR_COUNT + ERR_CNT_W'(1);
          end else begin
            ERR_FLAG <= 1'b0;
          end
          DATA_OUT  <= data_calc;
          OUT_VALID <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          // Results stay put after release until the next word is corrected.
          if (OUT_READY) begin
            OUT_VALID <= 1'b0;
            IN_READY  <= 1'b1;
            state     <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_rx_deserializer.sv
// Directed vector bench for hamming_rx_deserializer; a second instance with a
// 2-bit counter shares the stimulus so saturation is observed alongside.
module tb_hamming_rx_deserializer;

  logic        CLK = 1'b0;
  logic        REST;
  logic        SERIAL_IN;
  logic        IN_VALID;
  logic        OUT_READY;
  logic        IN_READY,  in_ready_2;
  logic [10:0] DATA_OUT,  data_out_2;
  logic [3:0]  SYNDROME,  syndrome_2;
  logic        ERR_FLAG,  err_flag_2;
  logic        OUT_VALID, out_valid_2;
  logic [7:0]  ERR_COUNT;
  logic [1:0]  err_count_2;

  int vectors = 0;
  int miscompares = 0;
  int model_err_count = 0;

  always #5 CLK = ~CLK;

  hamming_rx_deserializer #(.ERR_CNT_W(8)) dut (
    .CLK(CLK), .REST(REST), .SERIAL_IN(SERIAL_IN), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .DATA_OUT(DATA_OUT), .SYNDROME(SYNDROME),
    .ERR_FLAG(ERR_FLAG), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .ERR_COUNT(ERR_COUNT)
  );

  hamming_rx_deserializer #(.ERR_CNT_W(2)) dut_sat (
    .CLK(CLK), .REST(REST), .SERIAL_IN(SERIAL_IN), .IN_VALID(IN_VALID),
    .IN_READY(in_ready_2), .DATA_OUT(data_out_2), .SYNDROME(syndrome_2),
    .ERR_FLAG(err_flag_2), .OUT_VALID(out_valid_2), .OUT_READY(OUT_READY),
    .ERR_COUNT(err_count_2)
  );

  typedef struct {
    string       name;
    logic [14:0] code;
    int          gap_at;
    logic [10:0] exp_data;
    logic [3:0]  exp_syn;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Sends one codeword position 1 first, optionally pausing 3 cycles before gap_at.
  task automatic applyStimulus(input logic [14:0] code, input int gap_at);
    for (int p = 0; p < 15; p++) begin
      if (p == gap_at) begin
        IN_VALID = 1'b0;
        repeat (3) tick();
      end
      SERIAL_IN = code[p];
      IN_VALID  = 1'b1;
      tick();
    end
    IN_VALID  = 1'b0;
    SERIAL_IN = 1'b0;
  endtask

  task automatic waitOutput(input string name);
    int n = 0;
    while (!OUT_VALID && n < 6) begin
      tick();
      n++;
    end
    checkOutput({name, ".out_valid"}, OUT_VALID, 1);
    checkOutput({name, ".latency"}, n, 2);
  endtask

  task automatic checkResult(input string name, input logic [10:0] d,
                             input logic [3:0] s, input logic e);
    if (e) model_err_count++;
    checkOutput({name, ".data"}, DATA_OUT, d);
    checkOutput({name, ".syndrome"}, SYNDROME, s);
    checkOutput({name, ".err_flag"}, ERR_FLAG, e);
    checkOutput({name, ".err_count"}, ERR_COUNT, model_err_count);
    checkOutput({name, ".err_count_sat"}, err_count_2,
                (model_err_count > 3) ? 3 : model_err_count);
    checkOutput({name, ".in_ready_hold"}, IN_READY, 0);
  endtask

  initial begin
    vecs[0] = '{"zero",        15'h0000, -1, 11'h000, 4'd0,  1'b0};
    vecs[1] = '{"zero_pos5",   15'h0010, -1, 11'h000, 4'd5,  1'b1};
    vecs[2] = '{"ones_pos3",   15'h7FFB, -1, 11'h7FF, 4'd3,  1'b1};
    vecs[3] = '{"ones_pos8",   15'h7F7F, -1, 11'h7FF, 4'd8,  1'b1};
    vecs[4] = '{"d1_gap",      15'h0007,  7, 11'h001, 4'd0,  1'b0};
    vecs[5] = '{"d1_pos12",    15'h0807, -1, 11'h001, 4'd12, 1'b1};
    vecs[6] = '{"double_1_2",  15'h0003, -1, 11'h001, 4'd3,  1'b1};
    vecs[7] = '{"zero_pos15",  15'h4000,  3, 11'h000, 4'd15, 1'b1};

    REST = 1'b1; SERIAL_IN = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
    repeat (2) tick();
    REST = 1'b0;

    checkOutput("reset.in_ready", IN_READY, 1);
    checkOutput("reset.out_valid", OUT_VALID, 0);
    checkOutput("reset.data", DATA_OUT, 0);
    checkOutput("reset.syndrome", SYNDROME, 0);
    checkOutput("reset.err_flag", ERR_FLAG, 0);
    checkOutput("reset.err_count", ERR_COUNT, 0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].code, vecs[i].gap_at);
      waitOutput(vecs[i].name);
      checkResult(vecs[i].name, vecs[i].exp_data, vecs[i].exp_syn, vecs[i].exp_err);
      tick();
      checkOutput({vecs[i].name, ".released"}, OUT_VALID, 0);
      checkOutput({vecs[i].name, ".in_ready_back"}, IN_READY, 1);
    end

    // Backpressure: hold for 10 cycles while upstream offers a bit that must be ignored.
    OUT_READY = 1'b0;
    applyStimulus(15'h0007 ^ 15'h0040, -1);
    waitOutput("bp");
    checkResult("bp", 11'h001, 4'd7, 1'b1);
    SERIAL_IN = 1'b1;
    IN_VALID  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checkOutput("bp.hold_valid", OUT_VALID, 1);
      checkOutput("bp.hold_ready", IN_READY, 0);
      checkOutput("bp.hold_data", DATA_OUT, 11'h001);
      checkOutput("bp.hold_syn", SYNDROME, 4'd7);
    end
    IN_VALID  = 1'b0;
    SERIAL_IN = 1'b0;
    OUT_READY = 1'b1;
    tick();
    checkOutput("bp.released", OUT_VALID, 0);
    checkOutput("bp.in_ready_back", IN_READY, 1);
    checkOutput("bp.data_kept", DATA_OUT, 11'h001);
    checkOutput("bp.err_flag_kept", ERR_FLAG, 1);
    applyStimulus(15'h0000, -1);
    waitOutput("after_bp");
    checkResult("after_bp", 11'h000, 4'd0, 1'b0);
    tick();

    checkOutput("saturated", err_count_2, 2'b11);

    // Reset after 7 bits discards the partial word and clears the counters.
    for (int p = 0; p < 7; p++) begin
      SERIAL_IN = 1'b1;
      IN_VALID  = 1'b1;
      tick();
    end
    IN_VALID = 1'b0;
    REST = 1'b1;
    tick();
    REST = 1'b0;
    model_err_count = 0;
    checkOutput("mid_reset.in_ready", IN_READY, 1);
    checkOutput("mid_reset.out_valid", OUT_VALID, 0);
    checkOutput("mid_reset.err_count", ERR_COUNT, 0);
    checkOutput("mid_reset.err_count_sat", err_count_2, 0);
    applyStimulus(15'h0007, -1);
    waitOutput("post_reset");
    checkResult("post_reset", 11'h001, 4'd0, 1'b0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hamming_rx_deserializer.md
Name: hamming_rx_deserializer

Overview:
- Receive stage of the (15,11) Hamming decode path.
- Collects one 15-bit codeword serially, one bit per handshake.
- Computes the 4-bit syndrome and corrects any single-bit error.
- Presents the corrected 11-bit data word, with a valid/ready handshake, to the decoding controller/shift-out stage that sits downstream.

Parameters:
- ERR_CNT_W, 8, width of the saturating corrected-word counter ERR_COUNT.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- REST  input  1  synchronous, active-high reset.
- SERIAL_IN  input  1  received code bit.
- IN_VALID  input  1  SERIAL_IN holds a valid bit this cycle.
- IN_READY  output  1  block accepts a bit this cycle.
- DATA_OUT  output  11  corrected data word.
- SYNDROME  output  4  syndrome of the last word (0 = no error).
- ERR_FLAG  output  1  last word had a nonzero syndrome and was corrected.
- OUT_VALID  output  1  DATA_OUT/SYNDROME/ERR_FLAG valid.
- OUT_READY  input  1  downstream takes the word.
- ERR_COUNT  output  ERR_CNT_W  number of corrected words; saturates at all-ones.

Behaviour:
- Interface: one clock CLK; reset REST is synchronous and active-high. REST sampled only at the CLK rising edge; no asynchronous path.
- Reset values: state=COLLECT, bit counter=0, shift register=0, IN_READY=1, OUT_VALID=0, DATA_OUT=0, SYNDROME=0, ERR_FLAG=0, ERR_COUNT=0.
- REST mid-word or mid-hold: the partial word or held word is discarded; there is no flush.
- Code positions are 1..15. Internal codeword bit CODE[p-1] holds position p.
- Parity bits sit at positions 1, 2, 4 and 8.
- Data mapping: DATA_OUT[0..10] = positions 3,5,6,7,9,10,11,12,13,14,15, in ascending order.
- Serial order: position 1 arrives first, position 15 last.
- A bit is accepted when IN_VALID & IN_READY at a rising edge. It is stored at position (count+1); then count increments.
- State COLLECT: IN_READY=1. On acceptance with count==14, store the bit, set count to 0 and go to CHECK. Otherwise stay.
- State CHECK: IN_READY=0. Register SYNDROME = XOR of the 4-bit indices p of all positions holding 1. Go to CORRECT.
- State CORRECT: IN_READY=0.
  - SYNDROME≠0: invert position SYNDROME, set ERR_FLAG=1, and increment ERR_COUNT unless it is all-ones.
  - SYNDROME=0: set ERR_FLAG=0.
  - Load DATA_OUT from the corrected word, set OUT_VALID=1 and go to HOLD.
- State HOLD: IN_READY=0. Outputs stay stable while OUT_VALID=1 & OUT_READY=0.
  - On OUT_READY=1: OUT_VALID=0 next cycle, go to COLLECT.
  - SYNDROME/ERR_FLAG/DATA_OUT keep their values until the next CORRECT.
- Latency: OUT_VALID rises 2 cycles after the edge that accepts bit 15.
- Minimum period: 15 + 3 cycles per word when IN_VALID and OUT_READY stay high.
- Gaps: IN_VALID low in COLLECT freezes count and register, so gaps are tolerated anywhere in the word.
- Bits offered while IN_READY=0 are not accepted. The upstream source holds them.
- Double-bit errors: not detected. The block flips whichever position the syndrome indicates, or none if the syndrome is 0.
- Counter width: 4-bit count, range 0..14 only.

Test Plan:
- Clean zero word: reset, then 15 bits of 0 with IN_VALID=1 and OUT_READY=1 → OUT_VALID 2 cycles after the 15th bit, DATA_OUT=11'h000, SYNDROME=0, ERR_FLAG=0, ERR_COUNT=0.
- Single error on zero word: all-zero codeword with position 5 sent as 1 → SYNDROME=4'd5, ERR_FLAG=1, DATA_OUT=11'h000, ERR_COUNT=1.
- All-ones codeword with position 3 sent as 0 → SYNDROME=4'd3, DATA_OUT=11'h7FF, ERR_FLAG=1.
- Parity-bit error: all-ones codeword with position 8 sent as 0 → SYNDROME=4'd8, DATA_OUT=11'h7FF, ERR_COUNT increments.
- Backpressure and gaps:
  - OUT_READY=0 for 10 cycles after OUT_VALID → outputs stable and IN_READY=0 throughout; on OUT_READY=1, the next word is accepted starting 1 cycle later.
  - IN_VALID low for 3 cycles mid-word → the word is still decoded correctly.
- Reset and saturation:
  - REST asserted after 7 bits → IN_READY=1, count restarts, and a following clean word decodes correctly.
  - With ERR_CNT_W=2, send 5 erroneous words → ERR_COUNT saturates at 2'b11.
